// File: rtl/sig_assert_checker_if.sv
// -----------------------------------------------------------------------------
// sig_assert_checker_if
// Bundles the monitored signals, per-channel controls, readout select and all
// checker results into one interface.
//   slave  : used by the checker (inputs *_i, results *_o)
//   master : used by whoever drives the checker and consumes its results
// Signals:
//   sig_i        monitored signals, one per channel
//   en_i         per-channel check enable
//   mode_i       per-channel mode, channel i at [2i+1:2i]
//                (0 level, 1 edge, 2 liveness, 3 pulse)
//   clr_i        synchronous clear of counters, sticky flags, window counters
//   rd_sel_i     channel selected for counter readout
//   rd_pass_o    pass counter of the selected channel (0 if out of range)
//   rd_fail_o    fail counter of the selected channel (0 if out of range)
//   pass_pulse_o one-cycle pass indication per channel
//   fail_pulse_o one-cycle failure indication per channel
//   fail_sticky_o failure flag per channel, held until clear or reset
//   any_fail_o   OR of all sticky flags
// -----------------------------------------------------------------------------
interface sig_assert_checker_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]   sig_i;
    logic [NUM_CH-1:0]   en_i;
    logic [2*NUM_CH-1:0] mode_i;
    logic                clr_i;
    logic [SEL_W-1:0]    rd_sel_i;
    logic [CNT_W-1:0]    rd_pass_o;
    logic [CNT_W-1:0]    rd_fail_o;
    logic [NUM_CH-1:0]   pass_pulse_o;
    logic [NUM_CH-1:0]   fail_pulse_o;
    logic [NUM_CH-1:0]   fail_sticky_o;
    logic                any_fail_o;

    modport slave (
        input  sig_i, en_i, mode_i, clr_i, rd_sel_i,
        output rd_pass_o, rd_fail_o, pass_pulse_o, fail_pulse_o,
               fail_sticky_o, any_fail_o
    );

    modport master (
        output sig_i, en_i, mode_i, clr_i, rd_sel_i,
        input  rd_pass_o, rd_fail_o, pass_pulse_o, fail_pulse_o,
               fail_sticky_o, any_fail_o
    );
endinterface

// File: rtl/sig_assert_checker.sv
// -----------------------------------------------------------------------------
// sig_assert_checker
// Multi-channel signal-assertion checker. Every rising clock edge each enabled
// channel evaluates its monitored signal according to its mode:
//   0 level    : high passes, low fails
//   1 edge     : a rising edge passes, never fails
//   2 liveness : high passes; WINDOW consecutive low samples fail
//   3 pulse    : a rising edge passes, every further high sample fails
// Per channel it keeps saturating pass/fail counters, one-cycle pass/fail
// pulses and a sticky fail flag. Counters are read through rd_sel_i.
// Ports:
//   clk  sole clock, all sampling on the rising edge
//   rst  asynchronous active-high reset, clears all state
//   bus  sig_assert_checker_if slave modport (see interface header)
// -----------------------------------------------------------------------------
module sig_assert_checker #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    sig_assert_checker_if.slave     bus
);
    localparam int WIN_W = $clog2(WINDOW + 1);

    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] MODE_LEVEL = 2'd0;
    localparam logic [1:0] MODE_EDGE  = 2'd1;
    localparam logic [1:0] MODE_LIVE  = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc);
        logic [CNT_W-1:0] res;
        if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Registered state
    logic [NUM_CH-1:0] prev_q;
    logic [WIN_W-1:0]  win_cnt_q  [NUM_CH];
    logic [WIN_W-1:0]  win_cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  pass_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  pass_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  fail_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  fail_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] fail_sticky_q, fail_sticky_d;
    logic [NUM_CH-1:0] pass_pulse_q,  pass_pulse_d;
    logic [NUM_CH-1:0] fail_pulse_q,  fail_pulse_d;
    logic              any_fail_q,    any_fail_d;

    // Per-sample evaluation results
    logic [NUM_CH-1:0] pass_s;
    logic [NUM_CH-1:0] fail_s;

    // Readout mux outputs
    logic [CNT_W-1:0]  rd_pass_s;
    logic [CNT_W-1:0]  rd_fail_s;

    // Evaluate every channel against its mode and advance its liveness window.
    always_comb begin
        pass_s = '0;
        fail_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            win_cnt_d[i] = '0;
            if (bus.en_i[i]) begin
                case (bus.mode_i[2*i +: 2])
                    MODE_LEVEL: begin
                        pass_s[i] = bus.sig_i[i];
                        fail_s[i] = ~bus.sig_i[i];
                    end
                    MODE_EDGE: begin
                        pass_s[i] = ~prev_q[i] & bus.sig_i[i];
                    end
                    MODE_LIVE: begin
                        if (bus.sig_i[i]) begin
                            pass_s[i]    = 1'b1;
                            win_cnt_d[i] = '0;
                        end else if ((win_cnt_q[i] + WIN_ONE) == WIN_LAST) begin
                            // Window exhausted: report and start a fresh window.
                            fail_s[i]    = 1'b1;
                            win_cnt_d[i] = '0;
                        end else begin
                            win_cnt_d[i] = win_cnt_q[i] + WIN_ONE;
                        end
                    end
                    MODE_PULSE: begin
                        pass_s[i] = ~prev_q[i] & bus.sig_i[i];
                        fail_s[i] =  prev_q[i] & bus.sig_i[i];
                    end
                    default: begin
                        pass_s[i]    = 1'b0;
                        fail_s[i]    = 1'b0;
                        win_cnt_d[i] = '0;
                    end
                endcase
            end else begin
                // Disabled channel: no verdict, window restarts.
                win_cnt_d[i] = '0;
            end
            if (bus.clr_i) begin
                win_cnt_d[i] = '0;
            end else begin
                win_cnt_d[i] = win_cnt_d[i];
            end
        end
    end

    // Next-state of counters, sticky flags and pulses; clear wins over updates.
    always_comb begin
        fail_sticky_d = '0;
        pass_pulse_d  = pass_s;
        fail_pulse_d  = fail_s;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.clr_i) begin
                pass_cnt_d[i]    = '0;
                fail_cnt_d[i]    = '0;
                fail_sticky_d[i] = 1'b0;
            end else begin
                pass_cnt_d[i]    = sat_inc(pass_cnt_q[i], pass_s[i]);
                fail_cnt_d[i]    = sat_inc(fail_cnt_q[i], fail_s[i]);
                fail_sticky_d[i] = fail_sticky_q[i] | fail_s[i];
            end
        end
        any_fail_d = |fail_sticky_d;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q        <= '0;
            fail_sticky_q <= '0;
            pass_pulse_q  <= '0;
            fail_pulse_q  <= '0;
            any_fail_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                win_cnt_q[i]  <= '0;
                pass_cnt_q[i] <= '0;
                fail_cnt_q[i] <= '0;
            end
        end else begin
            // prev tracks sig unconditionally, independent of en and clr.
            prev_q        <= bus.sig_i;
            fail_sticky_q <= fail_sticky_d;
            pass_pulse_q  <= pass_pulse_d;
            fail_pulse_q  <= fail_pulse_d;
            any_fail_q    <= any_fail_d;
            for (int i = 0; i < NUM_CH; i++) begin
                win_cnt_q[i]  <= win_cnt_d[i];
                pass_cnt_q[i] <= pass_cnt_d[i];
                fail_cnt_q[i] <= fail_cnt_d[i];
            end
        end
    end

    // Counter readout; out-of-range selects read as zero.
    always_comb begin
        rd_pass_s = '0;
        rd_fail_s = '0;
        if (int'(bus.rd_sel_i) < NUM_CH) begin
            rd_pass_s = pass_cnt_q[bus.rd_sel_i];
            rd_fail_s = fail_cnt_q[bus.rd_sel_i];
        end else begin
            rd_pass_s = '0;
            rd_fail_s = '0;
        end
    end

    assign bus.rd_pass_o     = rd_pass_s;
    assign bus.rd_fail_o     = rd_fail_s;
    assign bus.pass_pulse_o  = pass_pulse_q;
    assign bus.fail_pulse_o  = fail_pulse_q;
    assign bus.fail_sticky_o = fail_sticky_q;
    assign bus.any_fail_o    = any_fail_q;

endmodule

// File: tb/tb_sig_assert_checker.sv
// -----------------------------------------------------------------------------
// tb_sig_assert_checker
// Self-checking bench for sig_assert_checker (NUM_CH=5, CNT_W=4, WINDOW=8).
// A behavioural reference model predicts each cycle's results when stimulus is
// driven on the falling edge; the prediction is queued and compared after the
// next rising edge. Hand-written constants cover the key sequence points.
// -----------------------------------------------------------------------------
module tb_sig_assert_checker;
    localparam int NCH = 5;
    localparam int CW  = 4;
    localparam int WIN = 8;
    localparam int CMAX = 15;

    logic clk;
    logic rst;

    sig_assert_checker_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    sig_assert_checker #(.NUM_CH(NCH), .CNT_W(CW), .WINDOW(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] pp;
        logic [NCH-1:0] fp;
        logic [NCH-1:0] st;
        logic           af;
        logic [CW-1:0]  rp;
        logic [CW-1:0]  rf;
    } exp_t;

    // Stimulus/expectation record for the single-channel hand sequences.
    typedef struct {
        logic sig;
        logic exp_pass;
        logic exp_fail;
    } vec_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_prev   [NCH];
    int m_win    [NCH];
    int m_pass   [NCH];
    int m_fail   [NCH];
    bit m_sticky [NCH];

    // Last observed DUT values for hand checks
    logic [NCH-1:0] last_pp, last_fp, last_st;
    logic           last_af;
    logic [CW-1:0]  last_rp, last_rf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_prev[i] = 1'b0; m_win[i] = 0; m_pass[i] = 0;
            m_fail[i] = 0; m_sticky[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [NCH-1:0] s, input logic [NCH-1:0] en,
                              input logic [2*NCH-1:0] md, input logic c,
                              input logic [2:0] rs, output exp_t e);
        bit p, f;
        int m;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            p = 1'b0; f = 1'b0;
            m = int'(md[2*i +: 2]);
            if (en[i] && m == 0) begin
                p = s[i]; f = !s[i];
            end
            if (en[i] && m == 1) p = !m_prev[i] && s[i];
            if (en[i] && m == 3) begin
                p = !m_prev[i] && s[i]; f = m_prev[i] && s[i];
            end
            if (en[i] && m == 2) begin
                if (s[i]) begin
                    p = 1'b1; m_win[i] = 0;
                end else if (m_win[i] + 1 == WIN) begin
                    f = 1'b1; m_win[i] = 0;
                end else begin
                    m_win[i] = m_win[i] + 1;
                end
            end else begin
                m_win[i] = 0;
            end
            if (p && m_pass[i] < CMAX) m_pass[i]++;
            if (f && m_fail[i] < CMAX) m_fail[i]++;
            if (f) m_sticky[i] = 1'b1;
            if (c) begin
                m_pass[i] = 0; m_fail[i] = 0; m_sticky[i] = 1'b0; m_win[i] = 0;
            end
            m_prev[i] = s[i];
            e.pp[i] = p;
            e.fp[i] = f;
            e.st[i] = m_sticky[i];
            if (m_sticky[i]) e.af = 1'b1;
        end
        if (int'(rs) < NCH) begin
            e.rp = CW'(m_pass[rs]);
            e.rf = CW'(m_fail[rs]);
        end
    endtask

    // Drive on the current falling edge, predict, compare after the rising edge.
    task automatic apply_check(input logic [NCH-1:0] s, input logic [NCH-1:0] en,
                               input logic [2*NCH-1:0] md, input logic c,
                               input logic [2:0] rs);
        exp_t e;
        bus.sig_i = s; bus.en_i = en; bus.mode_i = md; bus.clr_i = c; bus.rd_sel_i = rs;
        model_step(s, en, md, c, rs, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        last_pp = bus.pass_pulse_o; last_fp = bus.fail_pulse_o;
        last_st = bus.fail_sticky_o; last_af = bus.any_fail_o;
        last_rp = bus.rd_pass_o;    last_rf = bus.rd_fail_o;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("pass_pulse",  32'(last_pp), 32'(e.pp));
            check("fail_pulse",  32'(last_fp), 32'(e.fp));
            check("fail_sticky", 32'(last_st), 32'(e.st));
            check("any_fail",    32'(last_af), 32'(e.af));
            check("rd_pass_cnt", 32'(last_rp), 32'(e.rp));
            check("rd_fail_cnt", 32'(last_rf), 32'(e.rf));
        end
    endtask

    task automatic step(input logic [NCH-1:0] s, input logic [NCH-1:0] en,
                        input logic [2*NCH-1:0] md, input logic c,
                        input logic [2:0] rs);
        @(negedge clk);
        apply_check(s, en, md, c, rs);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_pass"},  32'(bus.rd_pass_o), 32'd0);
        check({tag, "_rd_fail"},  32'(bus.rd_fail_o), 32'd0);
        check({tag, "_pp"},       32'(bus.pass_pulse_o), 32'd0);
        check({tag, "_fp"},       32'(bus.fail_pulse_o), 32'd0);
        check({tag, "_sticky"},   32'(bus.fail_sticky_o), 32'd0);
        check({tag, "_any_fail"}, 32'(bus.any_fail_o), 32'd0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t edge_tab  [8];
        vec_t pulse_tab [5];
        logic [9:0] lvl_bits;
        logic       tmp;
        int         j;
        int         fails_seen;

        localparam logic [2*NCH-1:0] MD_LEVEL0 = 10'b00_00_00_00_00;
        localparam logic [2*NCH-1:0] MD_EDGE1  = 10'b00_00_00_01_00;
        localparam logic [2*NCH-1:0] MD_LIVE2  = 10'b00_00_10_00_00;
        localparam logic [2*NCH-1:0] MD_PULSE3 = 10'b00_11_00_00_00;

        // Edge mode: 0,1,1,0,1,0,1,1 -> passes at samples 2,5,7
        edge_tab[0] = '{1'b0, 1'b0, 1'b0};
        edge_tab[1] = '{1'b1, 1'b1, 1'b0};
        edge_tab[2] = '{1'b1, 1'b0, 1'b0};
        edge_tab[3] = '{1'b0, 1'b0, 1'b0};
        edge_tab[4] = '{1'b1, 1'b1, 1'b0};
        edge_tab[5] = '{1'b0, 1'b0, 1'b0};
        edge_tab[6] = '{1'b1, 1'b1, 1'b0};
        edge_tab[7] = '{1'b1, 1'b0, 1'b0};
        // Pulse mode: low, three highs, low -> pass then two fails
        pulse_tab[0] = '{1'b0, 1'b0, 1'b0};
        pulse_tab[1] = '{1'b1, 1'b1, 1'b0};
        pulse_tab[2] = '{1'b1, 1'b0, 1'b1};
        pulse_tab[3] = '{1'b1, 1'b0, 1'b1};
        pulse_tab[4] = '{1'b0, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1;
        bus.sig_i = '0; bus.en_i = '0; bus.mode_i = '0; bus.clr_i = 1'b0; bus.rd_sel_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Level mode, ch0: 10 samples containing 6 ones in random order
        lvl_bits = 10'b00_0011_1111;
        for (int k = 9; k > 0; k--) begin
            j = $urandom_range(k, 0);
            tmp = lvl_bits[k]; lvl_bits[k] = lvl_bits[j]; lvl_bits[j] = tmp;
        end
        for (int k = 0; k < 10; k++) begin
            step({4'b0000, lvl_bits[k]}, 5'b00001, MD_LEVEL0, 1'b0, 3'd0);
        end
        check("level_pass_cnt", 32'(last_rp), 32'd6);
        check("level_fail_cnt", 32'(last_rf), 32'd4);
        check("level_sticky0",  32'(last_st[0]), 32'd1);
        check("level_any_fail", 32'(last_af), 32'd1);

        // Edge mode, ch1 (table)
        for (int k = 0; k < 8; k++) begin
            step({3'b000, edge_tab[k].sig, 1'b0}, 5'b00010, MD_EDGE1, 1'b0, 3'd1);
            check("edge_tab_pass", 32'(last_pp[1]), 32'(edge_tab[k].exp_pass));
            check("edge_tab_fail", 32'(last_fp[1]), 32'(edge_tab[k].exp_fail));
        end
        check("edge_pass_cnt", 32'(last_rp), 32'd3);
        check("edge_fail_cnt", 32'(last_rf), 32'd0);
        check("edge_sticky1",  32'(last_st[1]), 32'd0);

        // Liveness mode, ch2: 20 low samples then one high
        fails_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            step(5'b00000, 5'b00100, MD_LIVE2, 1'b0, 3'd2);
            check("live_fail_pos", 32'(last_fp[2]), (k == 8 || k == 16) ? 32'd1 : 32'd0);
            if (last_fp[2]) fails_seen++;
        end
        check("live_fail_seen", 32'(fails_seen), 32'd2);
        step(5'b00100, 5'b00100, MD_LIVE2, 1'b0, 3'd2);
        check("live_pass_pulse", 32'(last_pp[2]), 32'd1);
        check("live_pass_cnt",   32'(last_rp), 32'd1);
        check("live_fail_cnt",   32'(last_rf), 32'd2);
        // Window restarted: 7 more lows must not fail, the 8th must
        for (int k = 1; k <= 8; k++) begin
            step(5'b00000, 5'b00100, MD_LIVE2, 1'b0, 3'd2);
            check("live_restart", 32'(last_fp[2]), (k == 8) ? 32'd1 : 32'd0);
        end

        // Pulse mode, ch3 (table)
        for (int k = 0; k < 5; k++) begin
            step({1'b0, pulse_tab[k].sig, 3'b000}, 5'b01000, MD_PULSE3, 1'b0, 3'd3);
            check("pulse_tab_pass", 32'(last_pp[3]), 32'(pulse_tab[k].exp_pass));
            check("pulse_tab_fail", 32'(last_fp[3]), 32'(pulse_tab[k].exp_fail));
        end
        check("pulse_pass_cnt", 32'(last_rp), 32'd1);
        check("pulse_fail_cnt", 32'(last_rf), 32'd2);

        // Saturation: 20 more level failures on ch0
        for (int k = 0; k < 20; k++) begin
            step(5'b00000, 5'b00001, MD_LEVEL0, 1'b0, 3'd0);
        end
        check("sat_fail_cnt", 32'(last_rf), 32'd15);
        step(5'b00000, 5'b00001, MD_LEVEL0, 1'b0, 3'd0);
        check("sat_fail_held", 32'(last_rf), 32'd15);

        // Out-of-range readout
        step(5'b00000, 5'b00000, MD_LEVEL0, 1'b0, 3'd5);
        check("oor_rd_pass", 32'(last_rp), 32'd0);
        check("oor_rd_fail", 32'(last_rf), 32'd0);

        // Clear together with a failing sample
        step(5'b00000, 5'b00001, MD_LEVEL0, 1'b1, 3'd0);
        check("clr_fail_pulse", 32'(last_fp[0]), 32'd1);
        check("clr_fail_cnt",   32'(last_rf), 32'd0);
        check("clr_sticky",     32'(last_st), 32'd0);
        check("clr_any_fail",   32'(last_af), 32'd0);

        // Build up counters, then async reset between edges
        for (int k = 0; k < 3; k++) begin
            step(5'b00001, 5'b00001, MD_LEVEL0, 1'b0, 3'd0);
        end
        check("pre_reset_pass", 32'(last_rp), 32'd3);
        step(5'b00000, 5'b00001, MD_LEVEL0, 1'b0, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        bus.sig_i = 5'b00010; bus.en_i = 5'b00010; bus.mode_i = MD_EDGE1; bus.rd_sel_i = 3'd1;
        @(negedge clk);
        rst = 1'b0;
        apply_check(5'b00010, 5'b00010, MD_EDGE1, 1'b0, 3'd1);
        check("post_reset_edge", 32'(last_pp[1]), 32'd1);
        check("post_reset_cnt",  32'(last_rp), 32'd1);
        step(5'b00010, 5'b00010, MD_EDGE1, 1'b0, 3'd1);
        check("post_reset_held", 32'(last_pp[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
